fir_axil_ctrl: RTL and testbench
================================

# fir_axil_ctrl

AXI-Lite responder and control-register block for the FIR accelerator. It answers the configuration writes and reads issued by the host or testbench, and holds `ap_ctrl` and `data_length`. It owns the tap-coefficient BRAM port while the engine is idle and hands that port to the FIR datapath while a run is in progress. It sits between the AXI-Lite bus and the FIR engine/tap RAM inside `fir`.

## Interface
Parameters:
- pADDR_WIDTH, 12, AXI-Lite and BRAM address width
- pDATA_WIDTH, 32, data width
- Tape_Num, 11, number of taps

Ports:
- axis_clk  in  1  single clock; all logic on rising edge
- axis_rst  in  1  reset, asynchronous, active-high
- awvalid / awready  in / out  1  write-address handshake
- awaddr  in  pADDR_WIDTH  write byte address
- wvalid / wready  in / out  1  write-data handshake
- wdata  in  pDATA_WIDTH  write data
- arvalid / arready  in / out  1  read-address handshake
- araddr  in  pADDR_WIDTH  read address
- rvalid / rready  out / in  1  read-data handshake
- rdata  out  pDATA_WIDTH  read data
- tap_WE  out  4  tap RAM byte write enables
- tap_EN  out  1  tap RAM enable
- tap_Di  out  pDATA_WIDTH  tap RAM write data
- tap_A  out  pADDR_WIDTH  tap RAM byte address
- tap_Do  in  pDATA_WIDTH  tap RAM read data (1-cycle latency)
- eng_tap_A  in  pADDR_WIDTH  engine tap address, used while busy
- eng_tap_EN  in  1  engine tap enable, used while busy
- ap_start_pulse  out  1  one-cycle start strobe to the engine
- eng_done  in  1  one-cycle pulse from the engine: last output accepted
- data_length  out  32  programmed sample count

## Operation
Address map:
- 0x00 ap_ctrl: bit0 ap_start, bit1 ap_done, bit2 ap_idle. Other bits read 0.
- 0x10 data_length.
- 0x20+k, k=0..Tape_Num-1: tap k. Decode is awaddr[11:4]==0x02 with low nibble < Tape_Num. The BRAM address is k*4.
- Any other address: writes are dropped and reads return 0.

Control behaviour:
- Writing bit0=1 to 0x00 while ap_idle=1 sets ap_start. Writing it while busy is ignored.
- The cycle after ap_start is set, ap_start_pulse is high for one cycle. On that same edge, ap_start clears and ap_idle clears.
- eng_done sets ap_done and sets ap_idle.
- Reading 0x00 returns the current value and then clears ap_done (clear-on-read). If eng_done and the clearing read land in the same cycle, the set wins.
- data_length is writable only while idle. Writes while busy are dropped.

Tap RAM port ownership:
- Idle: the AXI path owns the port.
- Busy: tap_A and tap_EN come from eng_tap_A and eng_tap_EN, with tap_WE=0. AXI tap writes are acked and dropped. AXI tap reads return 0.

Write/read FSM, three states: IDLE, WACK, RWAIT.
- IDLE → WACK when awvalid&&wvalid. Write has priority when arvalid is high in the same cycle.
- IDLE → RWAIT when arvalid && !(awvalid&&wvalid).
- WACK → IDLE after 1 cycle.
- RWAIT → IDLE on rvalid&&rready.

## Timing
Reset values: awready, wready, arready, rvalid, ap_start_pulse, tap_EN = 0; tap_WE = 0; rdata = 0; data_length = 0; ap_start = 0; ap_done = 0; ap_idle = 1.

Write (both valids sampled high at edge N):
- Registered awready=wready=1 during cycle N+1 only.
- The register or BRAM write commits at edge N+1: tap_EN=1, tap_WE=4'hF, tap_Di=wdata.
- The accept requires awvalid and wvalid together. A lone awvalid or lone wvalid is not accepted.
- No write response channel.

Read (arvalid sampled at edge N):
- arready=1 during N+1. For tap reads, tap_A and tap_EN are driven in N+1.
- rvalid rises at N+2 with rdata: tap_Do for taps, register value otherwise.
- rdata and rvalid are held until rready. Read-to-rvalid latency is fixed at 2 for all addresses.

Other timing rules:
- At least one idle cycle separates consecutive handshakes.
- The ownership switch to or from the engine takes effect the cycle after ap_start_pulse or eng_done.
- Reset asserted mid-transaction aborts it. All state returns to reset values and no partial BRAM write occurs after the reset edge.

## Structure
- Shared package `fir_pkg` holds:
  - Address constants: ADDR_AP_CTRL=0x00, ADDR_DLEN=0x10, ADDR_TAP_BASE=0x20.
  - ap_ctrl bit positions.
  - FSM state enum.
- No sub-module. The block is a flat FSM plus a register file and port mux.

## Test plan
- Reset → ap_ctrl reads 0x4; data_length reads 0.
- Write 0x10=600 → data_length=600; read 0x10 returns 600 with rvalid two cycles after arvalid.
- Write taps 0, -10, -9, 23, 56, 63, 56, 23, -9, -10, 0 to 0x20..0x2A → tap_A = 0, 4, …, 40 with tap_WE=F; read-back matches each value, and -10 reads as 0xFFFFFFF6.
- Write 0x00=1 → one ap_start_pulse; ap_ctrl reads 0x0 while busy; a tap write of 99 to 0x23 is dropped and 0x23 still reads 23 after done.
- Pulse eng_done → read 0x00 returns 0x6, then 0x4; when eng_done coincides with that read, ap_done stays 1.
- Drive awvalid and arvalid in the same cycle → write serviced first, read follows; assert axis_rst mid-read → rvalid=0 immediately.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared constants and types for the FIR AXI-Lite control block.
package fir_pkg;

  // Register map (byte addresses within the 12-bit AXI-Lite window)
  localparam logic [11:0] ADDR_AP_CTRL  = 12'h000;
  localparam logic [11:0] ADDR_DLEN     = 12'h010;
  localparam logic [11:0] ADDR_TAP_BASE = 12'h020;

  // ap_ctrl bit positions
  localparam int unsigned AP_START_BIT = 0;
  localparam int unsigned AP_DONE_BIT  = 1;
  localparam int unsigned AP_IDLE_BIT  = 2;

  // AXI-Lite responder states
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WACK  = 2'd1,
    S_RWAIT = 2'd2
  } axil_state_t;

endpackage

// File: rtl/fir_axil_ctrl.sv
// AXI-Lite responder, ap_ctrl/data_length registers and tap-RAM port owner.
module fir_axil_ctrl
  import fir_pkg::*;
#(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32,
  parameter int Tape_Num    = 11
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst,
  input  logic                   awvalid,
  output logic                   awready,
  input  logic [pADDR_WIDTH-1:0] awaddr,
  input  logic                   wvalid,
  output logic                   wready,
  input  logic [pDATA_WIDTH-1:0] wdata,
  input  logic                   arvalid,
  output logic                   arready,
  input  logic [pADDR_WIDTH-1:0] araddr,
  output logic                   rvalid,
  input  logic                   rready,
  output logic [pDATA_WIDTH-1:0] rdata,
  output logic [3:0]             tap_WE,
  output logic                   tap_EN,
  output logic [pDATA_WIDTH-1:0] tap_Di,
  output logic [pADDR_WIDTH-1:0] tap_A,
  input  logic [pDATA_WIDTH-1:0] tap_Do,
  input  logic [pADDR_WIDTH-1:0] eng_tap_A,
  input  logic                   eng_tap_EN,
  output logic                   ap_start_pulse,
  input  logic                   eng_done,
  output logic [31:0]            data_length
);

  localparam logic [pADDR_WIDTH-1:0] A_CTRL = pADDR_WIDTH'(ADDR_AP_CTRL);
  localparam logic [pADDR_WIDTH-1:0] A_DLEN = pADDR_WIDTH'(ADDR_DLEN);

  function automatic logic f_is_tap(input logic [pADDR_WIDTH-1:0] a);
    return (a[11:4] == ADDR_TAP_BASE[11:4]) && (32'(a[3:0]) < 32'(Tape_Num));
  endfunction

  function automatic logic [pADDR_WIDTH-1:0] f_tap_addr(input logic [pADDR_WIDTH-1:0] a);
    return pADDR_WIDTH'({a[3:0], 2'b00});
  endfunction

  axil_state_t r_state, w_next;

  logic                   r_awready, r_wready, r_arready, r_rvalid;
  logic [pADDR_WIDTH-1:0] r_waddr, r_raddr;
  logic [pDATA_WIDTH-1:0] r_wdata, r_rdata, w_reg_rdata;
  logic                   r_rd_tap, r_rd_live;
  logic                   r_ap_start, r_ap_done, r_ap_idle, r_start_pulse, r_eng_own;
  logic [31:0]            r_dlen;

  logic w_wr_req, w_wr_acc, w_rd_acc, w_commit, w_start_wr, w_ctrl_rd;

  assign w_wr_req   = awvalid && wvalid;
  assign w_wr_acc   = (r_state == S_IDLE) && w_wr_req;
  assign w_rd_acc   = (r_state == S_IDLE) && !w_wr_req && arvalid;
  assign w_commit   = (r_state == S_WACK);
  assign w_start_wr = w_commit && (r_waddr == A_CTRL) && r_wdata[AP_START_BIT] && r_ap_idle;
  assign w_ctrl_rd  = r_arready && (r_raddr == A_CTRL);

  // FSM state register
  always_ff @(posedge axis_clk or posedge axis_rst) begin
    if (axis_rst) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // FSM next-state: write wins over a simultaneous read request
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_wr_req)     w_next = S_WACK;
        else if (arvalid) w_next = S_RWAIT;
      end
      S_WACK:  w_next = S_IDLE;
      S_RWAIT: if (r_rvalid && rready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Handshake strobes and latched request fields
  always_ff @(posedge axis_clk or posedge axis_rst) begin
    if (axis_rst) begin
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_arready <= 1'b0;
      r_waddr   <= '0;
      r_wdata   <= '0;
      r_raddr   <= '0;
      r_rd_tap  <= 1'b0;
    end else begin
      r_awready <= w_wr_acc;
      r_wready  <= w_wr_acc;
      r_arready <= w_rd_acc;
      if (w_wr_acc) begin
        r_waddr <= awaddr;
        r_wdata <= wdata;
      end
      if (w_rd_acc) begin
        r_raddr  <= araddr;
        r_rd_tap <= f_is_tap(araddr) && !r_eng_own;
      end
    end
  end

  // Register read mux (taps are served from the RAM, not from here)
  always_comb begin
    w_reg_rdata = '0;
    if (r_raddr == A_CTRL) begin
      w_reg_rdata[AP_START_BIT] = r_ap_start;
      w_reg_rdata[AP_DONE_BIT]  = r_ap_done;
      w_reg_rdata[AP_IDLE_BIT]  = r_ap_idle;
    end else if (r_raddr == A_DLEN) begin
      w_reg_rdata = pDATA_WIDTH'(r_dlen);
    end
  end

  // Read data: tap_Do is passed straight through in the first rvalid cycle,
  // then captured so the response stays stable while waiting for rready.
  always_ff @(posedge axis_clk or posedge axis_rst) begin
    if (axis_rst) begin
      r_rvalid  <= 1'b0;
      r_rd_live <= 1'b0;
      r_rdata   <= '0;
    end else if (r_arready) begin
      r_rvalid  <= 1'b1;
      r_rd_live <= r_rd_tap;
      r_rdata   <= w_reg_rdata;
    end else begin
      if (r_rd_live) begin
        r_rdata   <= tap_Do;
        r_rd_live <= 1'b0;
      end
      if (r_rvalid && rready) r_rvalid <= 1'b0;
    end
  end

  // Control registers: start strobe, done/idle status, ownership, data_length
  always_ff @(posedge axis_clk or posedge axis_rst) begin
    if (axis_rst) begin
      r_ap_start    <= 1'b0;
      r_ap_done     <= 1'b0;
      r_ap_idle     <= 1'b1;
      r_start_pulse <= 1'b0;
      r_eng_own     <= 1'b0;
      r_dlen        <= '0;
    end else begin
      r_start_pulse <= r_ap_start;
      if (r_ap_start) begin
        r_ap_start <= 1'b0;
        r_ap_idle  <= 1'b0;
      end else if (w_start_wr) begin
        r_ap_start <= 1'b1;
      end
      if (eng_done) begin
        r_ap_done <= 1'b1;
        r_ap_idle <= 1'b1;
      end else if (w_ctrl_rd) begin
        r_ap_done <= 1'b0;
      end
      if (eng_done)           r_eng_own <= 1'b0;
      else if (r_start_pulse) r_eng_own <= 1'b1;
      if (w_commit && (r_waddr == A_DLEN) && r_ap_idle) r_dlen <= 32'(r_wdata);
    end
  end

  // Tap RAM port mux: engine while it owns the port, otherwise AXI
  always_comb begin
    tap_EN = 1'b0;
    tap_WE = 4'h0;
    tap_A  = '0;
    tap_Di = '0;
    if (r_eng_own) begin
      tap_A  = eng_tap_A;
      tap_EN = eng_tap_EN;
    end else if (w_commit && f_is_tap(r_waddr)) begin
      tap_EN = 1'b1;
      tap_WE = 4'hF;
      tap_A  = f_tap_addr(r_waddr);
      tap_Di = r_wdata;
    end else if (r_arready && r_rd_tap) begin
      tap_EN = 1'b1;
      tap_A  = f_tap_addr(r_raddr);
    end
  end

  assign awready        = r_awready;
  assign wready         = r_wready;
  assign arready        = r_arready;
  assign rvalid         = r_rvalid;
  assign rdata          = r_rd_live ? tap_Do : r_rdata;
  assign ap_start_pulse = r_start_pulse;
  assign data_length    = r_dlen;

endmodule

// File: tb/tb_fir_axil_ctrl.sv
// Self-checking bench for fir_axil_ctrl with a 1-cycle tap RAM model.
module tb_fir_axil_ctrl;

  localparam int AW = 12;
  localparam int DW = 32;
  localparam int NT = 11;

  logic          clk = 1'b0;
  logic          rst;
  logic          awvalid, awready, wvalid, wready, arvalid, arready, rvalid, rready;
  logic [AW-1:0] awaddr, araddr, tap_A, eng_tap_A;
  logic [DW-1:0] wdata, rdata, tap_Di, tap_Do;
  logic [3:0]    tap_WE;
  logic          tap_EN, eng_tap_EN, ap_start_pulse, eng_done;
  logic [31:0]   data_length;

  fir_axil_ctrl #(.pADDR_WIDTH(AW), .pDATA_WIDTH(DW), .Tape_Num(NT)) dut (
    .axis_clk(clk), .axis_rst(rst),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
    .wvalid(wvalid), .wready(wready), .wdata(wdata),
    .arvalid(arvalid), .arready(arready), .araddr(araddr),
    .rvalid(rvalid), .rready(rready), .rdata(rdata),
    .tap_WE(tap_WE), .tap_EN(tap_EN), .tap_Di(tap_Di), .tap_A(tap_A), .tap_Do(tap_Do),
    .eng_tap_A(eng_tap_A), .eng_tap_EN(eng_tap_EN),
    .ap_start_pulse(ap_start_pulse), .eng_done(eng_done), .data_length(data_length)
  );

  always #5 clk = ~clk;

  // Tap BRAM: synchronous read/write, one cycle of read latency
  logic [DW-1:0] mem [16];
  initial begin
    for (int i = 0; i < 16; i++) mem[i] = '0;
    tap_Do = '0;
  end
  always @(posedge clk) begin
    if (tap_EN) begin
      if (tap_WE == 4'hF) mem[tap_A[5:2]] <= tap_Di;
      tap_Do <= mem[tap_A[5:2]];
    end
  end

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  // Reference model of the programmer-visible state
  logic [31:0] m_tap [NT];
  logic [31:0] m_dlen;
  logic        m_done, m_idle, m_busy;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic m_is_tap(input logic [AW-1:0] a);
    return (a[11:4] == 8'h02) && (32'(a[3:0]) < NT);
  endfunction

  function automatic logic [31:0] m_read(input logic [AW-1:0] a);
    if (a == 12'h000) return {29'd0, m_idle, m_done, 1'b0};
    if (a == 12'h010) return m_dlen;
    if (m_is_tap(a))  return m_busy ? 32'd0 : m_tap[a[3:0]];
    return 32'd0;
  endfunction

  task automatic axi_write(input logic [AW-1:0] a, input logic [31:0] d);
    awvalid = 1'b1; wvalid = 1'b1; awaddr = a; wdata = d;
    tick();
    check("wr_ready", 32'({awready, wready}), 32'h3);
    awvalid = 1'b0; wvalid = 1'b0;
    if (!m_busy) begin
      if (m_is_tap(a)) begin
        check("wr_tap_en_we", 32'({tap_EN, tap_WE}), 32'h1F);
        check("wr_tap_A", 32'(tap_A), 32'(a[3:0]) * 4);
        check("wr_tap_Di", tap_Di, d);
      end else begin
        check("wr_notap_en", 32'(tap_EN), 32'd0);
      end
    end
    tick();
    check("wr_ready_drop", 32'({awready, wready}), 32'h0);
    if (m_is_tap(a) && !m_busy) m_tap[a[3:0]] = d;
    if (a == 12'h010 && m_idle) m_dlen = d;
  endtask

  task automatic axi_read(input string tag, input logic [AW-1:0] a, input bit done_mid,
                          output logic [31:0] got);
    logic [31:0] exp;
    int unsigned hold;
    exp = m_read(a);
    arvalid = 1'b1; araddr = a;
    tick();
    check("rd_arready", 32'({arready, rvalid}), 32'h2);
    arvalid = 1'b0;
    if (m_is_tap(a) && !m_busy) begin
      check("rd_tap_en", 32'({tap_EN, tap_WE}), 32'h10);
      check("rd_tap_A", 32'(tap_A), 32'(a[3:0]) * 4);
    end
    if (done_mid) eng_done = 1'b1;
    tick();
    eng_done = 1'b0;
    check("rd_latency2", 32'(rvalid), 32'd1);
    hold = $urandom_range(0, 3);
    for (int unsigned i = 0; i < hold; i++) begin
      check(tag, rdata, exp);
      tick();
      check("rd_rvalid_hold", 32'(rvalid), 32'd1);
    end
    check(tag, rdata, exp);
    got = rdata;
    rready = 1'b1;
    tick();
    rready = 1'b0;
    check("rd_rvalid_clr", 32'(rvalid), 32'd0);
    if (done_mid) begin
      m_done = 1'b1; m_idle = 1'b1; m_busy = 1'b0;
    end else if (a == 12'h000) begin
      m_done = 1'b0;
    end
  endtask

  task automatic start_run();
    axi_write(12'h000, 32'h1);
    check("pulse_pre", 32'(ap_start_pulse), 32'd0);
    tick();
    check("pulse_hi", 32'(ap_start_pulse), 32'd1);
    tick();
    check("pulse_one", 32'(ap_start_pulse), 32'd0);
    m_idle = 1'b0; m_busy = 1'b1;
  endtask

  task automatic end_run();
    eng_done = 1'b1;
    tick();
    eng_done = 1'b0;
    m_done = 1'b1; m_idle = 1'b1; m_busy = 1'b0;
    tick();
  endtask

  task automatic model_reset();
    m_dlen = '0; m_done = 1'b0; m_idle = 1'b1; m_busy = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          init_taps [NT];
    logic [31:0] rd, v;
    logic [AW-1:0] a;
    int unsigned order [NT];

    init_taps = '{0, -10, -9, 23, 56, 63, 56, 23, -9, -10, 0};
    for (int i = 0; i < NT; i++) m_tap[i] = '0;
    model_reset();
    rst = 1'b1;
    awvalid = 0; wvalid = 0; arvalid = 0; rready = 0; eng_done = 0; eng_tap_EN = 0;
    awaddr = '0; araddr = '0; wdata = '0; eng_tap_A = '0;
    tick(); tick();
    check("rst_ready", 32'({awready, wready, arready, rvalid}), 32'h0);
    check("rst_outs", 32'({ap_start_pulse, tap_EN, tap_WE}), 32'h0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_dlen", data_length, 32'h0);
    rst = 1'b0;
    tick();

    axi_read("ctrl_reset", 12'h000, 1'b0, rd);
    axi_read("dlen_reset", 12'h010, 1'b0, rd);

    axi_write(12'h010, 32'd600);
    check("dlen_port", data_length, 32'd600);
    axi_read("dlen_600", 12'h010, 1'b0, rd);

    for (int i = 0; i < NT; i++) axi_write(12'h020 + 12'(i), 32'(init_taps[i]));
    for (int i = 0; i < NT; i++) begin
      axi_read("tap_rb", 12'h020 + 12'(i), 1'b0, rd);
      if (i == 1) check("tap_neg10", rd, 32'hFFFFFFF6);
    end

    axi_write(12'h02B, 32'h1234);
    axi_read("tap_oob", 12'h02B, 1'b0, rd);
    axi_read("unmapped", 12'h014, 1'b0, rd);

    // Run 1: busy behaviour
    start_run();
    eng_tap_A = 12'(4 * $urandom_range(0, NT - 1));
    eng_tap_EN = 1'b1;
    #1;
    check("eng_mux_A", 32'(tap_A), 32'(eng_tap_A));
    check("eng_mux_en_we", 32'({tap_EN, tap_WE}), 32'h10);
    eng_tap_EN = 1'b0;
    axi_read("ctrl_busy", 12'h000, 1'b0, rd);
    axi_write(12'h023, 32'd99);
    axi_read("tap_busy_zero", 12'h023, 1'b0, rd);
    axi_write(12'h010, 32'd77);
    check("dlen_busy_drop", data_length, 32'd600);
    axi_write(12'h000, 32'h1);
    end_run();
    axi_read("ctrl_done", 12'h000, 1'b0, rd);
    axi_read("ctrl_cleared", 12'h000, 1'b0, rd);
    axi_read("tap3_kept", 12'h023, 1'b0, rd);

    // Run 2: eng_done lands on the clearing read
    start_run();
    axi_read("ctrl_busy2", 12'h000, 1'b0, rd);
    axi_read("ctrl_coincide", 12'h000, 1'b1, rd);
    axi_read("ctrl_set_wins", 12'h000, 1'b0, rd);
    axi_read("ctrl_after", 12'h000, 1'b0, rd);

    // Randomized tap/data_length traffic with random gaps
    for (int i = 0; i < NT; i++) order[i] = i;
    for (int i = NT - 1; i > 0; i--) begin
      int unsigned j, t;
      j = $urandom_range(0, i);
      t = order[i]; order[i] = order[j]; order[j] = t;
    end
    for (int i = 0; i < NT; i++) begin
      axi_write(12'h020 + 12'(order[i]), $urandom);
      repeat ($urandom_range(0, 2)) tick();
    end
    v = $urandom;
    axi_write(12'h010, v);
    for (int i = NT - 1; i >= 0; i--) begin
      axi_read("tap_rand", 12'h020 + 12'(order[i]), 1'b0, rd);
      repeat ($urandom_range(0, 2)) tick();
    end
    axi_read("dlen_rand", 12'h010, 1'b0, rd);

    // Simultaneous write and read requests: write first
    v = $urandom;
    awvalid = 1'b1; wvalid = 1'b1; awaddr = 12'h010; wdata = v;
    arvalid = 1'b1; araddr = 12'h010;
    tick();
    check("prio_wr_first", 32'({awready, arready}), 32'h2);
    awvalid = 1'b0; wvalid = 1'b0;
    tick();
    check("prio_gap", 32'(arready), 32'd0);
    m_dlen = v;
    tick();
    check("prio_rd_next", 32'(arready), 32'd1);
    arvalid = 1'b0;
    tick();
    check("prio_rvalid", 32'(rvalid), 32'd1);
    check("prio_rdata", rdata, v);
    rready = 1'b1; tick(); rready = 1'b0;

    // Reset in the middle of a read
    arvalid = 1'b1; araddr = 12'h010;
    tick();
    arvalid = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    check("rst_mid_rd", 32'({rvalid, arready}), 32'h0);
    @(negedge clk); rst = 1'b0;
    model_reset();
    tick();

    // Reset in the middle of a tap write: no BRAM write may follow
    a = 12'h025;
    awvalid = 1'b1; wvalid = 1'b1; awaddr = a; wdata = ~m_tap[5];
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    rst = 1'b1;
    #1;
    check("rst_mid_wr", 32'({tap_EN, tap_WE, awready}), 32'h0);
    @(negedge clk); rst = 1'b0;
    tick();
    axi_read("tap5_no_partial", a, 1'b0, rd);
    axi_read("ctrl_post_rst", 12'h000, 1'b0, rd);
    axi_read("dlen_post_rst", 12'h010, 1'b0, rd);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
